spi_cfg_sequencer: RTL

//  Parametrised SPI register-load sequencer for clock/ADC-front-end chips (CDCE6200x-class, LE-framed SPI).

---
 rtl/cfg_seq_pkg.sv | 18 +
 rtl/spi_word_shifter.sv | 108 ++++++++++
 rtl/spi_cfg_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cfg_seq_pkg.sv
// Shared types and helpers for the SPI configuration sequencer.
package cfg_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_WR_SHIFT, ST_WR_LE, ST_GAP, ST_RD_SHIFT,
    ST_RD_LE, ST_RD_CLK, ST_CHECK, ST_NEXT, ST_DONE, ST_ERR
  } seq_state_e;

  typedef enum logic [1:0] {SH_IDLE, SH_SHIFT, SH_HOLD} sh_state_e;

  localparam logic [3:0] RD_CMD_DEF = 4'hE;

  // $clog2 floored at 1 so degenerate parameters still give a legal vector width.
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// One LE-framed SPI transfer: LE falls with the first MOSI bit, DATA_W SCLK pulses,
// LE held low for LE_HOLD cycles after the last fall. MISO captured on SCLK rise.
module spi_word_shifter
  import cfg_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV   = 4,
  parameter int LE_HOLD   = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic [DATA_W-1:0] tx_word_i,
  output logic [DATA_W-1:0] rx_word_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              le_o
);

  localparam int DW = clog2w(CLK_DIV);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int HW = clog2w(LE_HOLD + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LE_HOLD - 1);

  sh_state_e         st_q, st_d;
  logic [DW-1:0]     div_q;
  logic [BW-1:0]     bit_q;
  logic [HW-1:0]     hold_q;
  logic              sclk_q, le_q;
  logic [DATA_W-1:0] sh_q, rx_q;
  logic              tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) st_q <= SH_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      SH_IDLE:  if (go_i) st_d = SH_SHIFT;
      SH_SHIFT: if (tick && sclk_q && bit_q == BIT_LAST) st_d = SH_HOLD;
      SH_HOLD:  if (hold_q == HOLD_LAST) st_d = SH_IDLE;
      default:  st_d = SH_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (st_q != SH_IDLE);
    sclk_o    = sclk_q;
    le_o      = le_q;
    mosi_o    = (LSB_FIRST != 0) ? sh_q[0] : sh_q[DATA_W-1];
    rx_word_o = rx_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      bit_q  <= '0;
      hold_q <= '0;
      sclk_q <= 1'b0;
      le_q   <= 1'b1;
      sh_q   <= '0;
      rx_q   <= '0;
    end else begin
      case (st_q)
        SH_IDLE: if (go_i) begin
          le_q   <= 1'b0;
          sh_q   <= tx_word_i;
          div_q  <= '0;
          bit_q  <= '0;
          hold_q <= '0;
        end
        SH_SHIFT: begin
          div_q <= tick ? '0 : div_q + 1'b1;
          if (tick) begin
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              bit_q <= bit_q + 1'b1;
              rx_q  <= (LSB_FIRST != 0) ? {miso_i, rx_q[DATA_W-1:1]}
                                        : {rx_q[DATA_W-2:0], miso_i};
            end else if (bit_q != BIT_LAST) begin
              // MOSI only moves on the falling edge; the final fall leaves it alone.
              sh_q <= (LSB_FIRST != 0) ? {1'b0, sh_q[DATA_W-1:1]}
                                       : {sh_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        SH_HOLD: begin
          hold_q <= hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            le_q <= 1'b1;
            sh_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Walks a register table, writes each word over LE-framed SPI, optionally reads it
// back and compares under VFY_MASK, retrying up to MAX_RETRY times before flagging err.
module spi_cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 12,
  parameter int                CLK_DIV   = 4,
  parameter int                GAP_CYC   = 600,
  parameter int                LE_HOLD   = 4,
  parameter int                LSB_FIRST = 1,
  parameter int                VERIFY    = 1,
  parameter logic [3:0]        RD_CMD    = RD_CMD_DEF,
  parameter logic [DATA_W-1:0] VFY_MASK  = {DATA_W{1'b1}} & ~DATA_W'(32'hF),
  parameter int                MAX_RETRY = 3,
  localparam int               AW        = clog2w(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [AW-1:0]     tbl_addr_o,
  input  logic [DATA_W:0]   tbl_data_i,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic              spi_le_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [AW-1:0]     err_idx_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  localparam int GW = clog2w(GAP_CYC + 1);
  localparam int RW = clog2w(MAX_RETRY + 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(NUM_REGS - 1);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     addr_q, err_idx_q;
  logic [DATA_W-1:0] wr_q, rd_data_q, sh_tx, sh_rx;
  logic              vfy_q, mis_q, post_chk_q;
  logic [RW-1:0]     retry_q;
  logic [GW-1:0]     gap_q;
  logic              go_q, busy_q, done_q, err_q, rd_valid_q;
  logic              go_d, busy_d, rd_valid_d, gap_run;
  logic              sh_busy, sh_end, gap_end, match, last;

  assign sh_end  = !go_q && !sh_busy;
  assign gap_end = (gap_q == GAP_LAST);
  assign match   = (((rd_data_q ^ wr_q) & VFY_MASK) == '0);
  assign last    = (addr_q == ADDR_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_i) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_WR_SHIFT;
      ST_WR_SHIFT: if (sh_end) state_d = ST_WR_LE;
      ST_WR_LE:    state_d = ST_GAP;
      ST_GAP: if (gap_end) begin
        if (post_chk_q)                   state_d = mis_q ? ST_WR_SHIFT : ST_NEXT;
        else if ((VERIFY != 0) && vfy_q)  state_d = ST_RD_SHIFT;
        else                              state_d = ST_NEXT;
      end
      ST_RD_SHIFT: if (sh_end) state_d = ST_RD_LE;
      ST_RD_LE:    if (gap_end) state_d = ST_RD_CLK;
      ST_RD_CLK:   if (sh_end) state_d = ST_CHECK;
      // Every path out of CHECK except the error passes through GAP, since the
      // read-clock frame has just raised LE.
      ST_CHECK:    state_d = (!match && retry_q == RETRY_LAST) ? ST_ERR : ST_GAP;
      ST_NEXT:     state_d = last ? ST_DONE : ST_FETCH;
      ST_DONE:     state_d = ST_IDLE;
      ST_ERR:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    go_d       = (state_d != state_q) &&
                 (state_d == ST_WR_SHIFT || state_d == ST_RD_SHIFT || state_d == ST_RD_CLK);
    busy_d     = !(state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERR);
    rd_valid_d = (state_d == ST_CHECK) && (state_q != ST_CHECK);
    gap_run    = (state_q == ST_GAP || state_q == ST_RD_LE) && (state_d == state_q);
    case (state_q)
      ST_WR_SHIFT: sh_tx = tbl_data_i[DATA_W-1:0];
      ST_RD_SHIFT: sh_tx = DATA_W'({wr_q[3:0], RD_CMD});
      default:     sh_tx = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      wr_q       <= '0;
      vfy_q      <= 1'b0;
      retry_q    <= '0;
      mis_q      <= 1'b0;
      post_chk_q <= 1'b0;
      gap_q      <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      go_q       <= go_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      gap_q      <= gap_run ? gap_q + 1'b1 : '0;
      case (state_q)
        ST_IDLE: if (start_i) begin
          addr_q     <= '0;
          retry_q    <= '0;
          mis_q      <= 1'b0;
          post_chk_q <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
        end
        // Table data is valid here, one cycle after the address settled in FETCH.
        ST_WR_SHIFT: if (go_q) begin
          wr_q       <= tbl_data_i[DATA_W-1:0];
          vfy_q      <= tbl_data_i[DATA_W];
          post_chk_q <= 1'b0;
        end
        ST_RD_CLK: if (state_d == ST_CHECK) rd_data_q <= sh_rx;
        ST_CHECK: begin
          post_chk_q <= 1'b1;
          if (match) begin
            retry_q <= '0;
            mis_q   <= 1'b0;
          end else if (retry_q != RETRY_LAST) begin
            retry_q <= retry_q + 1'b1;
            mis_q   <= 1'b1;
          end else begin
            err_q     <= 1'b1;
            err_idx_q <= addr_q;
          end
        end
        ST_NEXT: begin
          retry_q    <= '0;
          mis_q      <= 1'b0;
          post_chk_q <= 1'b0;
          if (last) done_q <= 1'b1;
          else      addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tbl_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_idx_o  = err_idx_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

  spi_word_shifter #(
    .DATA_W   (DATA_W),
    .CLK_DIV  (CLK_DIV),
    .LE_HOLD  (LE_HOLD),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .go_i     (go_q),
    .tx_word_i(sh_tx),
    .rx_word_o(sh_rx),
    .busy_o   (sh_busy),
    .sclk_o   (spi_sclk_o),
    .mosi_o   (spi_mosi_o),
    .miso_i   (spi_miso_i),
    .le_o     (spi_le_o)
  );

endmodule
